// File: rtl/fsm_burst_rd_if.sv
// Bundle of request, wait-state and strobe signals between a requester and the
// burst-read sequencer. FSM_RD_ABORT_EN adds the abort request line.
interface fsm_burst_rd_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              ws;
`ifdef FSM_RD_ABORT_EN
  logic              abort;
`endif
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic              bs;
  logic              ds;
  logic              err;
  logic              busy;

`ifdef FSM_RD_ABORT_EN
  modport master (
    output start, base_addr, len, ws, abort,
    input  rd, addr, bs, ds, err, busy
  );
  modport slave (
    input  start, base_addr, len, ws, abort,
    output rd, addr, bs, ds, err, busy
  );
`else
  modport master (
    output start, base_addr, len, ws,
    input  rd, addr, bs, ds, err, busy
  );
  modport slave (
    input  start, base_addr, len, ws,
    output rd, addr, bs, ds, err, busy
  );
`endif
endinterface

// File: rtl/fsm_burst_rd.sv
// Burst-read sequencer: LEN+1 beats from a latched base address with per-beat
// wait-state timeout. Define FSM_RD_ABORT_EN to add the abort input.
module fsm_burst_rd #(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  fsm_burst_rd_if.slave bus
);

  localparam int                WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_DLY  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              rd_q, rd_d;
  logic              bs_q, bs_d;
  logic              ds_q, ds_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              abort_req;

`ifdef FSM_RD_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are decided from the transition being taken, so they are
  // registered together with the state and change on the same edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    rd_d    = 1'b0;
    bs_d    = 1'b0;
    ds_d    = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b1;

    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rem_d   = '0;
      wcnt_d  = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          if (bus.start) begin
            state_d = S_READ;
            addr_d  = bus.base_addr;
            rem_d   = bus.len;
            wcnt_d  = '0;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end

        S_READ: begin
          state_d = S_DLY;
          rd_d    = 1'b1;
        end

        S_DLY: begin
          if (bus.ws) begin
            if (wcnt_q == WCNT_LAST) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
              rd_d   = 1'b1;
            end
          end else if (rem_q == '0) begin
            state_d = S_DONE;
            bs_d    = 1'b1;
            ds_d    = 1'b1;
          end else begin
            state_d = S_READ;
            bs_d    = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            wcnt_d  = '0;
            rd_d    = 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end

        // Illegal encodings fall back to a clean idle with everything cleared.
        default: begin
          state_d = S_IDLE;
          addr_d  = '0;
          rem_d   = '0;
          wcnt_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      bs_q    <= 1'b0;
      ds_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      bs_q    <= bs_d;
      ds_q    <= ds_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rd   = rd_q;
  assign bus.addr = addr_q;
  assign bus.bs   = bs_q;
  assign bus.ds   = ds_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fsm_burst_rd.sv
// Randomized bench for fsm_burst_rd: a transaction-level timeline model predicts
// every output cycle; directed bursts pin the model with literal counts.
module tb_fsm_burst_rd;

  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsm_burst_rd_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  fsm_burst_rd #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  last_addr = 8'h00;
  int          waits[16];
  logic        force_start = 1'b0;
`ifdef FSM_RD_ABORT_EN
  logic        abort_drv = 1'b0;
`endif

  // Observed-output tallies, cleared by the driver around directed bursts.
  int rd_cnt, bs_cnt, ds_cnt, err_cnt, busy_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Packed output vector {rd, addr, bs, ds, err, busy}.
  function automatic logic [12:0] o(input logic r, input logic [7:0] a, input logic b,
                                    input logic d, input logic e, input logic bz);
    return {r, a, b, d, e, bz};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.rd, bus.addr, bus.bs, bus.ds, bus.err, bus.busy};
  endfunction

  function automatic logic rs();
    return force_start ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // Compare process: one expected vector per clock edge while the queue is fed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check("outputs", 32'(dut_out()), 32'(exp_q.pop_front()));
        rd_cnt   += int'(bus.rd);
        bs_cnt   += int'(bus.bs);
        ds_cnt   += int'(bus.ds);
        err_cnt  += int'(bus.err);
        busy_cnt += int'(bus.busy);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic s, input logic [7:0] b, input logic [3:0] l,
                      input logic w, input logic [12:0] e);
    @(negedge clk);
    bus.start     = s;
    bus.base_addr = b;
    bus.len       = l;
    bus.ws        = w;
`ifdef FSM_RD_ABORT_EN
    bus.abort     = abort_drv;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    step(1'b0, 8'($urandom), 4'($urandom), 1'($urandom), o(0, last_addr, 0, 0, 0, 0));
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    rd_cnt = 0; bs_cnt = 0; ds_cnt = 0; err_cnt = 0; busy_cnt = 0;
  endtask

  // Timeline of one burst: per beat a READ cycle, then the DLY cycles driven by
  // waits[k] (>= TIMEOUT means the beat times out), then DONE or ERR and idle.
  task automatic burst(input logic [7:0] base, input logic [3:0] len);
    logic [7:0] a;
    step(1'b1, base, len, 1'($urandom), o(1, base, 0, 0, 0, 1));
    for (int k = 0; k <= int'(len); k++) begin
      a = base + 8'(k);
      step(rs(), 8'($urandom), 4'($urandom), 1'($urandom), o(1, a, 0, 0, 0, 1));
      if (waits[k] >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++)
          step(rs(), 8'($urandom), 4'($urandom), 1'b1,
               (i == TIMEOUT - 1) ? o(0, a, 0, 0, 1, 1) : o(1, a, 0, 0, 0, 1));
        step(rs(), 8'($urandom), 4'($urandom), 1'($urandom), o(0, a, 0, 0, 0, 0));
        last_addr = a;
        return;
      end
      for (int i = 0; i < waits[k]; i++)
        step(rs(), 8'($urandom), 4'($urandom), 1'b1, o(1, a, 0, 0, 0, 1));
      if (k == int'(len)) begin
        step(rs(), 8'($urandom), 4'($urandom), 1'b0, o(0, a, 1, 1, 0, 1));
        step(rs(), 8'($urandom), 4'($urandom), 1'($urandom), o(0, a, 0, 0, 0, 0));
        last_addr = a;
      end else begin
        step(rs(), 8'($urandom), 4'($urandom), 1'b0, o(1, a + 8'd1, 1, 0, 0, 1));
      end
    end
  endtask

  task automatic zero_waits();
    for (int i = 0; i < 16; i++) waits[i] = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.ws = 1'b0;
`ifdef FSM_RD_ABORT_EN
    bus.abort = 1'b0;
`endif
    clear_counts();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'h0);
    rst = 1'b0;
    idle_cycle();
    idle_cycle();

    // Single beat, no wait.
    zero_waits(); drain(); clear_counts();
    burst(8'h10, 4'd0); drain();
    check("single_rd_cycles", rd_cnt, 2);
    check("single_bs", bs_cnt, 1);
    check("single_ds", ds_cnt, 1);
    check("single_busy_cycles", busy_cnt, 3);

    // Wrapping burst with start held high throughout.
    force_start = 1'b1; clear_counts();
    burst(8'hFE, 4'd3); drain();
    force_start = 1'b0;
    check("wrap_rd_cycles", rd_cnt, 8);
    check("wrap_bs", bs_cnt, 4);
    check("wrap_ds", ds_cnt, 1);
    check("wrap_final_addr", 32'(bus.addr), 32'h01);
    idle_cycle();

    // Three wait states on the first beat.
    zero_waits(); waits[0] = 3; clear_counts();
    burst(8'h40, 4'd1); drain();
    check("wait_rd_cycles", rd_cnt, 7);
    check("wait_bs", bs_cnt, 2);
    check("wait_ds", ds_cnt, 1);
    check("wait_err", err_cnt, 0);

    // Timeout on the first beat, then a fresh burst must be accepted.
    zero_waits(); waits[0] = TIMEOUT; clear_counts();
    burst(8'h80, 4'd2); drain();
    check("timeout_rd_cycles", rd_cnt, 16);
    check("timeout_err", err_cnt, 1);
    check("timeout_ds", ds_cnt, 0);
    check("timeout_hold_addr", 32'(bus.addr), 32'h80);
    zero_waits();
    burst(8'h81, 4'd0);

    // Asynchronous reset while waiting in DLY.
    step(1'b1, 8'h33, 4'd2, 1'b0, o(1, 8'h33, 0, 0, 0, 1));
    step(1'b0, 8'h00, 4'd0, 1'b1, o(1, 8'h33, 0, 0, 0, 1));
    step(1'b0, 8'h00, 4'd0, 1'b1, o(1, 8'h33, 0, 0, 0, 1));
    drain();
    check("pre_reset_rd", 32'(bus.rd), 32'h1);
    #1 rst = 1'b1;
    #1 check("async_reset", 32'(dut_out()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_addr = 8'h00;
    repeat (3) idle_cycle();

`ifdef FSM_RD_ABORT_EN
    // Abort in READ, then abort held in IDLE must not block the next start.
    clear_counts();
    step(1'b1, 8'h5A, 4'd3, 1'b0, o(1, 8'h5A, 0, 0, 0, 1));
    abort_drv = 1'b1;
    step(1'b1, 8'h00, 4'd0, 1'b0, o(0, 8'h5A, 0, 0, 0, 0));
    last_addr = 8'h5A;
    idle_cycle();
    step(1'b1, 8'h22, 4'd0, 1'b0, o(1, 8'h22, 0, 0, 0, 1));
    abort_drv = 1'b0;
    step(1'b0, 8'h00, 4'd0, 1'b0, o(1, 8'h22, 0, 0, 0, 1));
    step(1'b0, 8'h00, 4'd0, 1'b0, o(0, 8'h22, 1, 1, 0, 1));
    step(1'b0, 8'h00, 4'd0, 1'b0, o(0, 8'h22, 0, 0, 0, 0));
    last_addr = 8'h22;
    drain();
    check("abort_ds", ds_cnt, 1);
    check("abort_err", err_cnt, 0);
`endif

    // Random bursts with random waits, occasional timeouts and idle gaps.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 16; k++) begin
        int r;
        r = int'($urandom_range(0, 39));
        if (r < 26)      waits[k] = 0;
        else if (r < 37) waits[k] = int'($urandom_range(1, 4));
        else if (r < 39) waits[k] = TIMEOUT - 1;
        else             waits[k] = TIMEOUT;
      end
      burst(($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom),
            4'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    drain();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
